// File: rtl/bcd_display_scanner_pkg.sv
// ============================================================================
// bcd_display_scanner_pkg : shared segment codes and scanner defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_display_scanner_pkg;

  localparam int unsigned C_REFRESH_DIV_DEFAULT = 50000;
  localparam int unsigned C_NUM_DIGITS          = 4;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] C_SEG_0     = 7'h40;
  localparam logic [6:0] C_SEG_1     = 7'h79;
  localparam logic [6:0] C_SEG_2     = 7'h24;
  localparam logic [6:0] C_SEG_3     = 7'h30;
  localparam logic [6:0] C_SEG_4     = 7'h19;
  localparam logic [6:0] C_SEG_5     = 7'h12;
  localparam logic [6:0] C_SEG_6     = 7'h02;
  localparam logic [6:0] C_SEG_7     = 7'h78;
  localparam logic [6:0] C_SEG_8     = 7'h00;
  localparam logic [6:0] C_SEG_9     = 7'h10;
  localparam logic [6:0] C_SEG_DASH  = 7'h3F;
  localparam logic [6:0] C_SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// ============================================================================
// bcd_to_seg7 : combinational BCD to active-low 7-segment decode (dash if >9)
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_to_seg7
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = C_SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg_n = C_SEG_0;
      4'd1:    o_seg_n = C_SEG_1;
      4'd2:    o_seg_n = C_SEG_2;
      4'd3:    o_seg_n = C_SEG_3;
      4'd4:    o_seg_n = C_SEG_4;
      4'd5:    o_seg_n = C_SEG_5;
      4'd6:    o_seg_n = C_SEG_6;
      4'd7:    o_seg_n = C_SEG_7;
      4'd8:    o_seg_n = C_SEG_8;
      4'd9:    o_seg_n = C_SEG_9;
      default: o_seg_n = C_SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_display_scanner.sv
// ============================================================================
// bcd_display_scanner : 4-digit multiplexed BCD display driver with shadow latch
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = C_REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        latch,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        invalid
);

  localparam int unsigned          C_PRESC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(REFRESH_DIV - 1);

  logic [15:0]          shadow_q, shadow_d;
  logic [3:0]           shadow_dp_q, shadow_dp_d;
  logic [C_PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]           digit_idx_q, digit_idx_d;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic                 dp_q, dp_d;
  logic                 invalid_q, invalid_d;

  logic [3:0]           w_nibble;
  logic [6:0]           w_seg_dec;
  logic [3:0]           w_gt9;
  logic [3:0]           w_lead_zero;
  logic                 w_wrap;

  for (genvar k = 0; k < 4; k++) begin : g_nibble
    assign w_gt9[k] = (shadow_q[4*k +: 4] > 4'd9);
  end

  // Bit k set when digit k and every higher digit are zero; digit 0 never blanks.
  assign w_lead_zero = {shadow_q[15:12] == 4'd0, shadow_q[15:8] == 8'd0,
                        shadow_q[15:4] == 12'd0, 1'b0};
  assign w_nibble    = shadow_q[{digit_idx_q, 2'b00} +: 4];
  assign w_wrap      = (presc_q == C_PRESC_LAST);

  bcd_to_seg7 u_dec (
    .i_bcd   (w_nibble),
    .o_seg_n (w_seg_dec)
  );

  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    presc_d     = '0;
    digit_idx_d = '0;
    seg_d       = C_SEG_BLANK;
    an_d        = 4'hF;
    dp_d        = 1'b1;
    invalid_d   = |w_gt9;

    if (latch) begin
      shadow_d    = bcd_in;
      shadow_dp_d = dp_in;
    end

    if (enable) begin
      presc_d     = w_wrap ? '0 : presc_q + 1'b1;
      digit_idx_d = w_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
      seg_d       = (blank_lz && w_lead_zero[digit_idx_q]) ? C_SEG_BLANK : w_seg_dec;
      an_d        = ~(4'b0001 << digit_idx_q);
      dp_d        = ~shadow_dp_q[digit_idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      presc_q     <= '0;
      digit_idx_q <= '0;
      seg_q       <= C_SEG_BLANK;
      an_q        <= 4'hF;
      dp_q        <= 1'b1;
      invalid_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      presc_q     <= presc_d;
      digit_idx_q <= digit_idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
      invalid_q   <= invalid_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign dp      = dp_q;
  assign invalid = invalid_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
// ============================================================================
// tb_bcd_display_scanner : randomized self-checking bench with arithmetic model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_display_scanner;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        latch = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        invalid;

  int checks = 0;
  int errors = 0;

  // Reference model: enabled-edge count since the scan (re)started, plus shadow.
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_dp = '0;
  int          m_n = 0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'hF;
  logic        exp_dp = 1'b1;
  logic        exp_inv = 1'b0;
  logic [6:0]  seg_tab [0:9];

  bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .latch    (latch),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  task automatic model_dark();
    exp_seg = 7'h7F;
    exp_an  = 4'hF;
    exp_dp  = 1'b1;
  endtask

  task automatic model_edge();
    int idx;
    int dig;
    bit blank;
    if (reset) begin
      m_bcd = '0; m_dp = '0; m_n = 0; exp_inv = 1'b0;
      model_dark();
      return;
    end
    exp_inv = 1'b0;
    for (int k = 0; k < 4; k++)
      if (((m_bcd >> (4*k)) & 16'hF) > 9) exp_inv = 1'b1;
    if (enable) begin
      idx   = (m_n / DIV) % 4;
      dig   = int'((m_bcd >> (4*idx)) & 16'hF);
      blank = blank_lz && (idx > 0) && ((m_bcd >> (4*idx)) == 16'h0);
      exp_an      = 4'hF;
      exp_an[idx] = 1'b0;
      exp_seg     = blank ? 7'h7F : ((dig > 9) ? 7'h3F : seg_tab[dig]);
      exp_dp      = ~m_dp[idx];
      m_n++;
    end else begin
      model_dark();
      m_n = 0;
    end
    if (latch) begin
      m_bcd = bcd_in;
      m_dp  = dp_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if ({an, seg, dp, invalid} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b inv=%b, want an=F seg=7F dp=1 inv=0",
               an, seg, dp, invalid);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan_1234();
    logic [3:0] an_seq [0:3];
    logic [6:0] seg_seq [0:3];
    an_seq  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_seq = '{7'h19, 7'h30, 7'h24, 7'h79};
    bcd_in = 16'h1234; dp_in = 4'h0; latch = 1'b1; blank_lz = 1'b0;
    step();
    latch = 1'b0; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
        errors++;
        $display("FAIL scan_1234 cyc %0d: an=%h seg=%h dp=%b inv=%b, want an=%h seg=%h dp=%b inv=%b",
                 i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
      end
      if (i < 16) begin
        checks++;
        if ({an, seg} !== {an_seq[i/4], seg_seq[i/4]}) begin
          errors++;
          $display("FAIL scan_1234_seq cyc %0d: an=%h seg=%h, want an=%h seg=%h",
                   i, an, seg, an_seq[i/4], seg_seq[i/4]);
        end
      end
    end
  endtask

  task automatic test_blanking();
    enable = 1'b0; bcd_in = 16'h0005; latch = 1'b1; blank_lz = 1'b1;
    step();
    latch = 1'b0; enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) blank_lz = 1'b0;
      step();
      checks++;
      if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
        errors++;
        $display("FAIL blanking cyc %0d: an=%h seg=%h dp=%b inv=%b, want an=%h seg=%h dp=%b inv=%b",
                 i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
      end
    end
  endtask

  task automatic test_invalid_dp();
    bcd_in = 16'h00A7; dp_in = 4'b0100; latch = 1'b1;
    step();
    latch = 1'b0;
    step();
    checks++;
    if (invalid !== 1'b1) begin
      errors++;
      $display("FAIL invalid_set: inv=%b, want 1", invalid);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
        errors++;
        $display("FAIL invalid_dp cyc %0d: an=%h seg=%h dp=%b inv=%b, want an=%h seg=%h dp=%b inv=%b",
                 i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
      end
    end
    bcd_in = 16'h0007; latch = 1'b1;
    step();
    latch = 1'b0;
    step();
    checks++;
    if (invalid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_clear: inv=%b, want 0", invalid);
    end
  endtask

  task automatic test_enable_drop();
    repeat (6) step();
    enable = 1'b0;
    step();
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL enable_drop: an=%h seg=%h dp=%b, want an=F seg=7F dp=1", an, seg, dp);
    end
    step();
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
        errors++;
        $display("FAIL reenable cyc %0d: an=%h seg=%h dp=%b inv=%b, want an=%h seg=%h dp=%b inv=%b",
                 i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
      end
      if (i == 0) begin
        checks++;
        if (an !== 4'hE) begin
          errors++;
          $display("FAIL reenable_first_an: an=%h, want E", an);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bcd_in = 16'h9876; dp_in = 4'hF; latch = 1'b1; blank_lz = 1'b0;
    step();
    step();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({an, seg, dp, invalid} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_dark: an=%h seg=%h dp=%b inv=%b, want an=F seg=7F dp=1 inv=0",
               an, seg, dp, invalid);
    end
    m_bcd = '0; m_dp = '0; m_n = 0; exp_inv = 1'b0;
    model_dark();
    latch = 1'b0;
    #1;
    reset = 1'b0;
    step();
    checks++;
    if ({an, seg, dp} !== {4'hE, 7'h40, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_shadow: an=%h seg=%h dp=%b, want an=E seg=40 dp=1", an, seg, dp);
    end
  endtask

  task automatic test_random();
    logic [3:0] nib;
    for (int i = 0; i < 400; i++) begin
      latch = ($urandom_range(0, 7) == 0);
      if (latch) begin
        for (int k = 0; k < 4; k++) begin
          nib = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          bcd_in[4*k +: 4] = nib;
        end
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      step();
      checks++;
      if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
        errors++;
        $display("FAIL random cyc %0d: an=%h seg=%h dp=%b inv=%b, want an=%h seg=%h dp=%b inv=%b",
                 i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
      end
    end
    latch = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    test_reset();
    test_scan_1234();
    test_blanking();
    test_invalid_dp();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
